cpu_clock_ctrl: RTL and testbench

//  Run/halt/single-step controller for the CPU clock. Issues a one-cycle clock-enable

---
 rtl/cpu_clock_ctrl_pkg.sv | 27 ++
 rtl/cpu_clock_ctrl_tick_gen.sv | 32 +++
 rtl/cpu_clock_ctrl.sv | 147 ++++++++++++++
 tb/tb_cpu_clock_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_clock_ctrl_pkg.sv
// Shared types for the CPU clock controller: FSM states, prescaler codes and
// the code-to-shift mapping used by the tick generator.
package cpu_clock_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam logic [1:0] PSC_DIV0 = 2'b00;
  localparam logic [1:0] PSC_DIV1 = 2'b01;
  localparam logic [1:0] PSC_DIV2 = 2'b10;
  localparam logic [1:0] PSC_DIV3 = 2'b11;

  // Code 00 is the undivided clock (shift 0, period 1).
  function automatic int psc_shift(input logic [1:0] code, input int s1, input int s2,
                                   input int s3);
    case (code)
      PSC_DIV1: return s1;
      PSC_DIV2: return s2;
      PSC_DIV3: return s3;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_clock_ctrl_tick_gen.sv
// Free-running prescale counter for the CPU clock controller; flags the last
// count of each 2^sh period.
module cpu_clk_tick_gen #(
  parameter int CNT_W = 24,
  parameter int SH_W  = 5
) (
  input  logic            clk,
  input  logic            res,
  input  logic            i_clr,
  input  logic            i_en,
  input  logic [SH_W-1:0] i_sh,
  output logic            o_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_mask;

  // Low sh bits set; a shift of 0 gives an empty mask so every count is a tick.
  assign w_mask = ~({CNT_W{1'b1}} << i_sh);
  assign o_tick = ((r_cnt & w_mask) == w_mask);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cpu_clock_ctrl.sv
// Run/halt/single-step controller issuing a prescaled one-cycle clock enable
// to the CPU core; prescaler changes take effect only on tick boundaries.
module cpu_clock_ctrl
  import cpu_clock_ctrl_pkg::*;
#(
  parameter int CNT_W  = 24,
  parameter int SHIFT1 = 1,
  parameter int SHIFT2 = 16,
  parameter int SHIFT3 = 24
) (
  input  logic       clk,
  input  logic       res,
  input  logic       run_req,
  input  logic       halt_req,
  input  logic       step_req,
  input  logic       cpu_halt,
  input  logic       psc_wr,
  input  logic [1:0] psc_in,
  output logic       clk_en,
  output logic       running,
  output logic       stepping,
  output logic [1:0] psc_cur,
  output logic       psc_pend
);

  localparam int SH_W = $clog2(CNT_W + 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_clk_en;
  logic [1:0]      r_psc_cur;
  logic [1:0]      r_psc_pend_code;
  logic            r_psc_pend;

  logic [SH_W-1:0] w_sh;
  logic            w_tick;
  logic            w_active;
  logic            w_halt_now;
  logic            w_psc_now;
  logic            w_psc_apply;
  logic            w_cnt_clr;

  assign w_sh       = SH_W'(psc_shift(r_psc_cur, SHIFT1, SHIFT2, SHIFT3));
  assign w_active   = (r_state != ST_HALT);
  assign w_halt_now = halt_req | ((r_state == ST_RUN) & cpu_halt);

  // Written codes apply at once only while staying halted; else they wait for a
  // tick, or for the edge that drops into HALT.
  assign w_psc_now   = psc_wr & (r_state == ST_HALT) & (w_state_nxt == ST_HALT);
  assign w_psc_apply = r_psc_pend & w_active & (w_tick | w_halt_now);
  assign w_cnt_clr   = w_psc_apply | w_psc_now |
                       ((r_state == ST_HALT) & (w_state_nxt != ST_HALT));

  cpu_clk_tick_gen #(
    .CNT_W (CNT_W),
    .SH_W  (SH_W)
  ) u_tick_gen (
    .clk    (clk),
    .res    (res),
    .i_clr  (w_cnt_clr),
    .i_en   (w_active),
    .i_sh   (w_sh),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state <= ST_HALT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (halt_req) begin
      w_state_nxt = ST_HALT;
    end else begin
      case (r_state)
        ST_HALT: begin
          if (run_req) begin
            w_state_nxt = ST_RUN;
          end else if (step_req) begin
            w_state_nxt = ST_STEP;
          end
        end
        ST_RUN: begin
          if (cpu_halt) begin
            w_state_nxt = ST_HALT;
          end
        end
        ST_STEP: begin
          if (run_req) begin
            w_state_nxt = ST_RUN;
          end else if (w_tick) begin
            w_state_nxt = ST_HALT;
          end
        end
        default: w_state_nxt = ST_HALT;
      endcase
    end
  end

  always_comb begin
    running  = 1'b0;
    stepping = 1'b0;
    case (r_state)
      ST_RUN:  running  = 1'b1;
      ST_STEP: stepping = 1'b1;
      default: ;
    endcase
  end

  // A halt on the same edge as a tick suppresses the pulse.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_clk_en <= 1'b0;
    end else begin
      r_clk_en <= w_tick & w_active & ~w_halt_now;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_psc_cur       <= PSC_DIV0;
      r_psc_pend_code <= PSC_DIV0;
      r_psc_pend      <= 1'b0;
    end else begin
      if (w_psc_now) begin
        r_psc_cur <= psc_in;
      end else if (w_psc_apply) begin
        r_psc_cur <= r_psc_pend_code;
      end
      if (psc_wr && !w_psc_now) begin
        r_psc_pend_code <= psc_in;
        r_psc_pend      <= 1'b1;
      end else if (w_psc_apply) begin
        r_psc_pend      <= 1'b0;
      end
    end
  end

  assign clk_en   = r_clk_en;
  assign psc_cur  = r_psc_cur;
  assign psc_pend = r_psc_pend;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed bench for cpu_clock_ctrl with short prescaler shifts (1/3/5, 8-bit counter).
module tb_cpu_clock_ctrl;

  logic       clk;
  logic       res;
  logic       run_req;
  logic       halt_req;
  logic       step_req;
  logic       cpu_halt;
  logic       psc_wr;
  logic [1:0] psc_in;
  logic       clk_en;
  logic       running;
  logic       stepping;
  logic [1:0] psc_cur;
  logic       psc_pend;

  int checks = 0;
  int errors = 0;

  cpu_clock_ctrl #(
    .CNT_W  (8),
    .SHIFT1 (1),
    .SHIFT2 (3),
    .SHIFT3 (5)
  ) dut (
    .clk      (clk),
    .res      (res),
    .run_req  (run_req),
    .halt_req (halt_req),
    .step_req (step_req),
    .cpu_halt (cpu_halt),
    .psc_wr   (psc_wr),
    .psc_in   (psc_in),
    .clk_en   (clk_en),
    .running  (running),
    .stepping (stepping),
    .psc_cur  (psc_cur),
    .psc_pend (psc_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_run();
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
  endtask

  task automatic pulse_halt();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
  endtask

  task automatic pulse_step();
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
  endtask

  task automatic wr_psc(input logic [1:0] code);
    psc_in = code;
    psc_wr = 1'b1;
    tick();
    psc_wr = 1'b0;
  endtask

  task automatic test_reset();
    res = 1'b0;
    #12;
    checks++;
    if ({clk_en, running, stepping, psc_cur, psc_pend} !== 6'b0) begin
      errors++;
      $display("FAIL reset_values: got %b expected 000000",
               {clk_en, running, stepping, psc_cur, psc_pend});
    end
    res = 1'b1;
    tick();
    pulse_run();
    tick();
    checks++;
    if (clk_en !== 1'b1 || running !== 1'b1) begin
      errors++;
      $display("FAIL reset_prerun: clk_en=%b running=%b expected 1 1", clk_en, running);
    end
    wr_psc(2'b11);
    checks++;
    if (psc_pend !== 1'b1) begin
      errors++;
      $display("FAIL reset_pend_set: got %b expected 1", psc_pend);
    end
    #2 res = 1'b0;
    #1;
    checks++;
    if ({clk_en, running, psc_cur, psc_pend} !== 5'b0) begin
      errors++;
      $display("FAIL reset_midrun: got %b expected 00000",
               {clk_en, running, psc_cur, psc_pend});
    end
    #2 res = 1'b1;
    tick();
    checks++;
    if (running !== 1'b0 || clk_en !== 1'b0 || psc_cur !== 2'b00) begin
      errors++;
      $display("FAIL reset_after: running=%b clk_en=%b psc_cur=%0d expected 0 0 0",
               running, clk_en, psc_cur);
    end
  endtask

  task automatic test_run_div1();
    int n;
    pulse_run();
    checks++;
    if (clk_en !== 1'b0 || running !== 1'b1) begin
      errors++;
      $display("FAIL div1_start: clk_en=%b running=%b expected 0 1", clk_en, running);
    end
    n = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (clk_en === 1'b1) n++;
    end
    pulse_halt();
    checks++;
    if (clk_en !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL div1_halt: clk_en=%b running=%b expected 0 0", clk_en, running);
    end
    checks++;
    if (n !== 9) begin
      errors++;
      $display("FAIL div1_pulse_count: got %0d expected 9", n);
    end
  endtask

  task automatic test_step();
    int first;
    int n;
    wr_psc(2'b10);
    checks++;
    if (psc_cur !== 2'b10 || psc_pend !== 1'b0) begin
      errors++;
      $display("FAIL step_psc_immediate: psc_cur=%0d psc_pend=%b expected 2 0",
               psc_cur, psc_pend);
    end
    for (int rep = 0; rep < 2; rep++) begin
      pulse_step();
      checks++;
      if (stepping !== 1'b1) begin
        errors++;
        $display("FAIL step_enter: stepping=%b expected 1", stepping);
      end
      first = 0;
      n = 0;
      for (int j = 1; j <= 8; j++) begin
        tick();
        if (clk_en === 1'b1) begin
          n++;
          if (first == 0) first = j;
        end
      end
      checks++;
      if (first !== 8 || n !== 1) begin
        errors++;
        $display("FAIL step_pulse_at: first=%0d count=%0d expected 8 1", first, n);
      end
      checks++;
      if (stepping !== 1'b0 || running !== 1'b0) begin
        errors++;
        $display("FAIL step_exit: stepping=%b running=%b expected 0 0", stepping, running);
      end
      n = 0;
      for (int j = 0; j < 50; j++) begin
        tick();
        if (clk_en === 1'b1) n++;
      end
      checks++;
      if (n !== 0) begin
        errors++;
        $display("FAIL step_quiet: got %0d pulses expected 0", n);
      end
    end
  endtask

  task automatic test_psc_change();
    int n;
    logic [3:0] pat;
    wr_psc(2'b11);
    pulse_run();
    for (int i = 1; i <= 4; i++) tick();
    psc_in = 2'b10;
    psc_wr = 1'b1;
    tick();
    checks++;
    if (psc_pend !== 1'b1 || psc_cur !== 2'b11) begin
      errors++;
      $display("FAIL psc_first_write: pend=%b cur=%0d expected 1 3", psc_pend, psc_cur);
    end
    psc_in = 2'b01;
    tick();
    psc_wr = 1'b0;
    checks++;
    if (psc_pend !== 1'b1 || psc_cur !== 2'b11) begin
      errors++;
      $display("FAIL psc_second_write: pend=%b cur=%0d expected 1 3", psc_pend, psc_cur);
    end
    n = 0;
    for (int i = 7; i <= 31; i++) begin
      tick();
      if (clk_en === 1'b1) n++;
    end
    checks++;
    if (n !== 0 || psc_cur !== 2'b11) begin
      errors++;
      $display("FAIL psc_before_boundary: pulses=%0d cur=%0d expected 0 3", n, psc_cur);
    end
    tick();
    checks++;
    if (clk_en !== 1'b1 || psc_cur !== 2'b01 || psc_pend !== 1'b0) begin
      errors++;
      $display("FAIL psc_boundary: clk_en=%b cur=%0d pend=%b expected 1 1 0",
               clk_en, psc_cur, psc_pend);
    end
    pat = 4'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      pat[i] = clk_en;
    end
    checks++;
    if (pat !== 4'b1010) begin
      errors++;
      $display("FAIL psc_div2_pattern: got %b expected 1010", pat);
    end
    pulse_halt();
  endtask

  task automatic test_cpu_halt();
    wr_psc(2'b00);
    cpu_halt = 1'b1;
    pulse_run();
    checks++;
    if (running !== 1'b1) begin
      errors++;
      $display("FAIL hlt_run_entered: running=%b expected 1", running);
    end
    tick();
    checks++;
    if (running !== 1'b0 || clk_en !== 1'b0) begin
      errors++;
      $display("FAIL hlt_auto_halt: running=%b clk_en=%b expected 0 0", running, clk_en);
    end
    pulse_step();
    checks++;
    if (stepping !== 1'b1) begin
      errors++;
      $display("FAIL hlt_step_enter: stepping=%b expected 1", stepping);
    end
    tick();
    checks++;
    if (clk_en !== 1'b1 || stepping !== 1'b0) begin
      errors++;
      $display("FAIL hlt_step_pulse: clk_en=%b stepping=%b expected 1 0", clk_en, stepping);
    end
    tick();
    checks++;
    if (clk_en !== 1'b0) begin
      errors++;
      $display("FAIL hlt_step_single: clk_en=%b expected 0", clk_en);
    end
    cpu_halt = 1'b0;
    pulse_run();
    tick();
    checks++;
    if (clk_en !== 1'b1) begin
      errors++;
      $display("FAIL hlt_rerun_pulse: clk_en=%b expected 1", clk_en);
    end
    pulse_halt();
    checks++;
    if (clk_en !== 1'b0 || running !== 1'b0) begin
      errors++;
      $display("FAIL hlt_halt_on_tick: clk_en=%b running=%b expected 0 0", clk_en, running);
    end
  endtask

  task automatic test_step_then_run();
    int n;
    wr_psc(2'b11);
    pulse_step();
    n = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (clk_en === 1'b1) n++;
    end
    pulse_run();
    checks++;
    if (running !== 1'b1 || stepping !== 1'b0 || n !== 0) begin
      errors++;
      $display("FAIL str_enter_run: running=%b stepping=%b pulses=%0d expected 1 0 0",
               running, stepping, n);
    end
    n = 0;
    for (int i = 11; i <= 31; i++) begin
      tick();
      if (clk_en === 1'b1) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL str_early_pulse: got %0d pulses expected 0", n);
    end
    tick();
    checks++;
    if (clk_en !== 1'b1) begin
      errors++;
      $display("FAIL str_boundary_pulse: clk_en=%b expected 1", clk_en);
    end
    tick();
    checks++;
    if (clk_en !== 1'b0 || running !== 1'b1) begin
      errors++;
      $display("FAIL str_after_pulse: clk_en=%b running=%b expected 0 1", clk_en, running);
    end
    pulse_halt();
  endtask

  initial begin
    res      = 1'b0;
    run_req  = 1'b0;
    halt_req = 1'b0;
    step_req = 1'b0;
    cpu_halt = 1'b0;
    psc_wr   = 1'b0;
    psc_in   = 2'b00;
    test_reset();
    test_run_div1();
    test_step();
    test_psc_change();
    test_cpu_halt();
    test_step_then_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
